// File: rtl/soft_tbm_pkg.sv
// Shared types and field layout for the soft-TBM readout sequencer.
// Queue entry layout assumes the default 36-bit payload plus token flag.
package soft_tbm_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_WAIT    = 2'd2,
    S_TRAILER = 2'd3
  } state_t;

  localparam int EV_MSB  = 36;
  localparam int EV_LSB  = 29;
  localparam int FLG_MSB = 28;
  localparam int FLG_LSB = 21;
  localparam int TOK_BIT = 0;

  localparam int TRL_TOK_TIMEOUT = 7;
  localparam int TRL_STACK_FULL  = 6;
  localparam int TRL_NO_TOKEN    = 5;

  localparam int HDR_W = 16;
  localparam int TRL_W = 16;

  typedef struct packed {
    logic [7:0] ev;
    logic [7:0] flags;
    logic       tok;
    logic       stack_full;
    logic       no_token;
    logic       tok_timeout;
  } evt_t;

endpackage

// File: rtl/soft_tbm_readout_if.sv
// Queue, ROC token and header/trailer word signals of the readout sequencer.
// master = sequencer side, slave = queue / ROC chain / event builder side.
interface soft_tbm_readout_if #(
  parameter int DATA_WIDTH = 36
);
  import soft_tbm_pkg::*;

  logic                  queue_empty;
  logic                  queue_full;
  logic [DATA_WIDTH:0]   queue_dout;
  logic                  queue_read;
  logic                  token_in;
  logic                  token_out;
  logic                  hdr_valid;
  logic [HDR_W-1:0]      hdr_data;
  logic                  trl_valid;
  logic [TRL_W-1:0]      trl_data;

  modport master (
    input  queue_empty, queue_full, queue_dout, token_in,
    output queue_read, token_out, hdr_valid, hdr_data, trl_valid, trl_data
  );

  modport slave (
    output queue_empty, queue_full, queue_dout, token_in,
    input  queue_read, token_out, hdr_valid, hdr_data, trl_valid, trl_data
  );

endinterface

// File: rtl/soft_tbm_token_timer.sv
// 8-bit saturating WAIT counter, advancing only on sync; expired compares the current count.
// Clear has priority over increment.
module soft_tbm_token_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sync,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (sync) begin
      if (clr) begin
        count <= '0;
      end else if (inc && count != 8'hFF) begin
        count <= count + 8'd1;
      end
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/soft_tbm_readout.sv
// Readout sequencer: header word, optional ROC token round-trip, trailer word and one pop per entry.
// Advances only on sync; 3 syncs per event plus WAIT syncs; stalls only by waiting for token return.
module soft_tbm_readout
  import soft_tbm_pkg::*;
#(
  parameter int DATA_WIDTH = 36
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [7:0]           token_timeout,
  soft_tbm_readout_if.master   bus,
  output logic                 busy
);

  state_t              state, state_nxt;
  evt_t                evt, evt_nxt;
  logic                hdr_valid, hdr_valid_nxt;
  logic                trl_valid, trl_valid_nxt;
  logic                token_out, token_out_nxt;
  logic [DATA_WIDTH:0] entry;
  logic                expired;
  logic                timer_clr;
  logic                timer_inc;
  logic                unused_bits;

  assign entry       = bus.queue_dout;
  assign unused_bits = ^entry[FLG_LSB-1:TOK_BIT+1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      evt       <= '0;
      hdr_valid <= 1'b0;
      trl_valid <= 1'b0;
      token_out <= 1'b0;
    end else if (sync) begin
      state     <= state_nxt;
      evt       <= evt_nxt;
      hdr_valid <= hdr_valid_nxt;
      trl_valid <= trl_valid_nxt;
      token_out <= token_out_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    evt_nxt       = evt;
    hdr_valid_nxt = hdr_valid;
    trl_valid_nxt = trl_valid;
    token_out_nxt = token_out;
    if (clear) begin
      state_nxt     = S_IDLE;
      evt_nxt       = '0;
      hdr_valid_nxt = 1'b0;
      trl_valid_nxt = 1'b0;
      token_out_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && !bus.queue_empty) begin
            evt_nxt.ev          = entry[EV_MSB:EV_LSB];
            evt_nxt.flags       = entry[FLG_MSB:FLG_LSB];
            evt_nxt.tok         = entry[TOK_BIT];
            evt_nxt.stack_full  = bus.queue_full;
            evt_nxt.no_token    = 1'b0;
            evt_nxt.tok_timeout = 1'b0;
            hdr_valid_nxt       = 1'b1;
            state_nxt           = S_HEADER;
          end
        end
        S_HEADER: begin
          hdr_valid_nxt = 1'b0;
          if (evt.tok) begin
            token_out_nxt = 1'b1;
            state_nxt     = S_WAIT;
          end else begin
            evt_nxt.no_token = 1'b1;
            trl_valid_nxt    = 1'b1;
            state_nxt        = S_TRAILER;
          end
        end
        S_WAIT: begin
          token_out_nxt = 1'b0;
          // A returned token beats a timeout expiring on the same sync.
          if (bus.token_in) begin
            trl_valid_nxt = 1'b1;
            state_nxt     = S_TRAILER;
          end else if (expired) begin
            evt_nxt.tok_timeout = 1'b1;
            trl_valid_nxt       = 1'b1;
            state_nxt           = S_TRAILER;
          end
        end
        S_TRAILER: begin
          trl_valid_nxt       = 1'b0;
          evt_nxt.stack_full  = 1'b0;
          evt_nxt.no_token    = 1'b0;
          evt_nxt.tok_timeout = 1'b0;
          state_nxt           = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign timer_clr = clear || (state == S_HEADER);
  assign timer_inc = (state == S_WAIT);

  soft_tbm_token_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .sync    (sync),
    .clr     (timer_clr),
    .inc     (timer_inc),
    .limit   (token_timeout),
    .expired (expired)
  );

  always_comb begin
    bus.trl_data                  = '0;
    bus.trl_data[TRL_W-1 -: 8]    = evt.ev;
    bus.trl_data[TRL_TOK_TIMEOUT] = evt.tok_timeout;
    bus.trl_data[TRL_STACK_FULL]  = evt.stack_full;
    bus.trl_data[TRL_NO_TOKEN]    = evt.no_token;
  end

  assign bus.hdr_data   = {evt.ev, evt.flags};
  assign bus.hdr_valid  = hdr_valid;
  assign bus.trl_valid  = trl_valid;
  assign bus.token_out  = token_out;
  assign bus.queue_read = (state == S_TRAILER) && !clear;
  assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_soft_tbm_readout.sv
// Directed and randomized bench for soft_tbm_readout against a per-event timeline model.
module tb_soft_tbm_readout;

  logic       clk;
  logic       reset_n;
  logic       sync;
  logic       enable;
  logic       clear;
  logic [7:0] token_timeout;
  logic       busy;

  soft_tbm_readout_if #(.DATA_WIDTH(36)) bus ();

  soft_tbm_readout #(.DATA_WIDTH(36)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sync          (sync),
    .enable        (enable),
    .clear         (clear),
    .token_timeout (token_timeout),
    .bus           (bus.master),
    .busy          (busy)
  );

  logic [36:0] q[$];
  bit          hide;
  int          pops;
  int          checks;
  int          errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_entry(input logic [7:0] ev, input logic [7:0] fl, input bit tok);
    logic [63:0] r;
    r = {$urandom, $urandom};
    q.push_back({ev, fl, r[19:0], tok});
  endtask

  // One sync edge; the queue model pops on the sync that sees queue_read.
  task automatic sstep();
    logic        rd;
    logic [63:0] r;
    @(negedge clk);
    r = {$urandom, $urandom};
    bus.queue_empty = (q.size() == 0) || hide;
    bus.queue_dout  = (q.size() == 0 || hide) ? r[36:0] : q[0];
    sync = 1'b1;
    #1 rd = bus.queue_read;
    @(posedge clk);
    if (rd && q.size() > 0) begin
      void'(q.pop_front());
      pops++;
    end
    #1 sync = 1'b0;
    @(negedge clk);
  endtask

  // Expected timeline: start, header, w WAIT syncs, trailer; w from return slot vs timeout.
  task automatic run_event(input logic [7:0] ev, input logic [7:0] fl, input bit tok,
                           input int ret, input int tmo, input bit sf, input bit stress);
    bit to_flag;
    int w;
    int len;
    int p0;
    to_flag = tok && !(ret != 0 && ret <= tmo + 1);
    w = !tok ? 0 : (to_flag ? tmo + 1 : ret);
    len = 3 + w;
    p0 = pops;
    token_timeout = 8'(tmo);
    for (int n = 0; n < len; n++) begin
      enable = (n == 0) ? 1'b1 : (stress ? 1'($urandom_range(0, 1)) : 1'b1);
      hide = (n != 0) && stress && ($urandom_range(0, 1) == 1);
      bus.queue_full = (n == 0) ? sf : 1'b0;
      if (tok && n >= 2 && n <= len - 2)
        bus.token_in = (ret != 0) && (n == 1 + ret);
      else
        bus.token_in = stress ? 1'($urandom_range(0, 1)) : 1'b0;
      sstep();
      chk1("busy", busy, n < len - 1);
      chk1("hdr_valid", bus.hdr_valid, n == 0);
      if (n == 0) chk16("hdr_data", bus.hdr_data, {ev, fl});
      chk1("token_out", bus.token_out, tok && (n == 1));
      chk1("trl_valid", bus.trl_valid, n == len - 2);
      if (n == len - 2) chk16("trl_data", bus.trl_data, {ev, to_flag, sf, ~tok, 5'b0});
      chk1("queue_read", bus.queue_read, n == len - 2);
    end
    chk16("pop_count", 16'(pops - p0), 16'd1);
    hide = 1'b0;
    bus.token_in = 1'b0;
  endtask

  initial begin
    logic [7:0] ev;
    logic [7:0] fl;
    bit         tok;
    bit         sf;
    int         tmo;
    int         ret;
    int         gap;
    int         p0;

    checks = 0; errors = 0; pops = 0; hide = 1'b0;
    reset_n = 1'b0; sync = 1'b0; enable = 1'b0; clear = 1'b0; token_timeout = '0;
    bus.queue_empty = 1'b1; bus.queue_full = 1'b0; bus.queue_dout = '0; bus.token_in = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_hdr_valid", bus.hdr_valid, 1'b0);
    chk1("rst_trl_valid", bus.trl_valid, 1'b0);
    chk1("rst_token_out", bus.token_out, 1'b0);
    chk1("rst_queue_read", bus.queue_read, 1'b0);
    chk16("rst_hdr_data", bus.hdr_data, 16'h0000);
    chk16("rst_trl_data", bus.trl_data, 16'h0000);
    reset_n = 1'b1;

    // Token returned 4 syncs after token_out.
    push_entry(8'h12, 8'h03, 1'b1);
    run_event(8'h12, 8'h03, 1'b1, 4, 20, 1'b0, 1'b0);
    // No-token entry.
    push_entry(8'hA5, 8'h5A, 1'b0);
    run_event(8'hA5, 8'h5A, 1'b0, 0, 20, 1'b0, 1'b0);
    // Token never returned, timeout 5 -> 6 WAIT syncs.
    push_entry(8'h33, 8'hC0, 1'b1);
    run_event(8'h33, 8'hC0, 1'b1, 0, 5, 1'b0, 1'b0);
    // Three back-to-back no-token events, queue full only at the first.
    for (int i = 0; i < 3; i++) push_entry(8'(8'h40 + i), 8'(8'h10 * i), 1'b0);
    for (int i = 0; i < 3; i++) run_event(8'(8'h40 + i), 8'(8'h10 * i), 1'b0, 0, 3, i == 0, 1'b0);
    // Token and zero timeout coincide on the first WAIT sync.
    push_entry(8'h66, 8'h01, 1'b1);
    run_event(8'h66, 8'h01, 1'b1, 1, 0, 1'b0, 1'b0);

    // Clear during WAIT.
    push_entry(8'h77, 8'h11, 1'b1);
    enable = 1'b1; token_timeout = 8'd50;
    sstep(); chk1("clr_hdr_valid", bus.hdr_valid, 1'b1);
    sstep(); chk1("clr_tok_out", bus.token_out, 1'b1);
    sstep(); chk1("clr_wait_busy", busy, 1'b1);
    chk1("clr_wait_tok_low", bus.token_out, 1'b0);
    p0 = pops; clear = 1'b1; enable = 1'b0;
    sstep(); clear = 1'b0;
    chk1("clr_busy", busy, 1'b0);
    chk1("clr_token_out", bus.token_out, 1'b0);
    chk1("clr_hdr_valid0", bus.hdr_valid, 1'b0);
    chk1("clr_trl_valid", bus.trl_valid, 1'b0);
    chk16("clr_hdr_data", bus.hdr_data, 16'h0000);
    chk16("clr_trl_data", bus.trl_data, 16'h0000);
    chk16("clr_no_pop", 16'(pops - p0), 16'd0);
    sstep(); chk1("clr_no_restart", busy, 1'b0);
    run_event(8'h77, 8'h11, 1'b1, 2, 50, 1'b0, 1'b0);

    // Clear during TRAILER suppresses the pop.
    push_entry(8'h88, 8'h22, 1'b0);
    enable = 1'b1;
    sstep(); sstep();
    chk1("trl_queue_read", bus.queue_read, 1'b1);
    p0 = pops; clear = 1'b1; enable = 1'b0;
    #1 chk1("clr_qr_comb", bus.queue_read, 1'b0);
    sstep(); clear = 1'b0;
    chk1("clr_trl_busy", busy, 1'b0);
    chk1("clr_trl_valid0", bus.trl_valid, 1'b0);
    chk16("clr_trl_no_pop", 16'(pops - p0), 16'd0);
    q.delete();

    // Reset asserted mid-WAIT, away from any sync edge.
    push_entry(8'h99, 8'h44, 1'b1);
    enable = 1'b1; token_timeout = 8'd50;
    sstep(); sstep();
    chk1("rw_tok_out", bus.token_out, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    chk1("rw_busy", busy, 1'b0);
    chk1("rw_token_out", bus.token_out, 1'b0);
    chk1("rw_hdr_valid", bus.hdr_valid, 1'b0);
    chk1("rw_trl_valid", bus.trl_valid, 1'b0);
    chk1("rw_queue_read", bus.queue_read, 1'b0);
    chk16("rw_hdr_data", bus.hdr_data, 16'h0000);
    chk16("rw_trl_data", bus.trl_data, 16'h0000);
    q.delete(); enable = 1'b0;
    @(negedge clk); reset_n = 1'b1;

    // Randomized events with noise on enable, queue_empty/dout and token_in outside WAIT.
    for (int k = 0; k < 40; k++) begin
      ev  = 8'($urandom);
      fl  = 8'($urandom);
      tok = 1'($urandom_range(0, 1));
      sf  = 1'($urandom_range(0, 1));
      tmo = int'($urandom_range(0, 6));
      ret = int'($urandom_range(0, 32'(tmo + 2)));
      push_entry(ev, fl, tok);
      gap = int'($urandom_range(0, 2));
      enable = 1'b0;
      for (int g = 0; g < gap; g++) begin
        sstep();
        chk1("gap_busy", busy, 1'b0);
      end
      run_event(ev, fl, tok, ret, tmo, sf, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
